// File: rtl/mem_sched_pkg.sv
// Shared encodings and defaults for the memory request scheduler.
// Source ids double as bit 0 of the memory tag.
package mem_sched_pkg;

    localparam logic SRC_IC = 1'b0;
    localparam logic SRC_DC = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } state_t;

    localparam int DEF_DATA_BEATS = 4;
    localparam int DEF_MAX_OUT    = 2;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_out_tracker.sv
// Per-source read bookkeeping: tag sequence number, outstanding-read count
// and response beat position.
module mem_out_tracker
    import mem_sched_pkg::*;
#(
    parameter int TAG_W      = 5,
    parameter int DATA_BEATS = DEF_DATA_BEATS,
    parameter int MAX_OUT    = DEF_MAX_OUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_accept,
    input  logic             i_resp_beat,
    output logic [TAG_W-2:0] o_seq,
    output logic             o_full
);

    localparam int OCW = cnt_w(MAX_OUT + 1);
    localparam int BCW = cnt_w(DATA_BEATS);

    logic [TAG_W-2:0] r_seq;
    logic [OCW-1:0]   r_out;
    logic [BCW-1:0]   r_beat;
    logic             w_last;
    logic             w_dec;

    assign w_last = i_resp_beat && (r_beat == BCW'(DATA_BEATS - 1));
    // A final beat with nothing outstanding is still routed but must not underflow.
    assign w_dec  = w_last && (r_out != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq  <= '0;
            r_out  <= '0;
            r_beat <= '0;
        end else begin
            if (i_accept)
                r_seq <= r_seq + 1'b1;
            if (i_resp_beat)
                r_beat <= w_last ? '0 : r_beat + 1'b1;
            if (i_accept && !w_dec)
                r_out <= r_out + 1'b1;
            else if (!i_accept && w_dec)
                r_out <= r_out - 1'b1;
        end
    end

    assign o_seq  = r_seq;
    assign o_full = (r_out >= OCW'(MAX_OUT));

endmodule

// File: rtl/mem_req_scheduler.sv
// Arbitrates icache/dcache onto one memory request channel, tags reads and
// steers response beats back by tag. MEM_SCHED_DC_PRIORITY_EN selects fixed dcache priority.
module mem_req_scheduler
    import mem_sched_pkg::*;
#(
    parameter int ADDR_W     = 28,
    parameter int TAG_W      = 5,
    parameter int DATA_BEATS = DEF_DATA_BEATS,
    parameter int MAX_OUT    = DEF_MAX_OUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_mem_req_valid,
    output logic              ic_mem_req_ready,
    input  logic [ADDR_W-1:0] ic_mem_req_addr,
    output logic              ic_mem_resp_valid,
    input  logic              dc_mem_req_valid,
    output logic              dc_mem_req_ready,
    input  logic              dc_mem_req_rw,
    input  logic [ADDR_W-1:0] dc_mem_req_addr,
    input  logic              dc_mem_req_data_valid,
    output logic              dc_mem_req_data_ready,
    output logic              dc_mem_resp_valid,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [TAG_W-1:0]  mem_req_tag,
    output logic              mem_req_data_valid,
    input  logic              mem_req_data_ready,
    input  logic              mem_resp_valid,
    input  logic [TAG_W-1:0]  mem_resp_tag
);

    localparam int WBW = cnt_w(DATA_BEATS);

    state_t           r_state;
    logic             r_lock;
    logic             r_lock_src;
    logic [WBW-1:0]   r_wbeat;
`ifndef MEM_SCHED_DC_PRIORITY_EN
    logic             r_rr_last;
`endif

    logic             w_ic_full;
    logic             w_dc_full;
    logic [TAG_W-2:0] w_ic_seq;
    logic [TAG_W-2:0] w_dc_seq;
    logic             w_ic_elig;
    logic             w_dc_elig;
    logic             w_gnt;
    logic             w_src;
    logic             w_accept;
    logic             w_wbeat;
    logic             w_ic_beat;
    logic             w_dc_beat;
    logic             w_unused_tag;

    assign w_ic_elig = ic_mem_req_valid && !w_ic_full;
    assign w_dc_elig = dc_mem_req_valid && (dc_mem_req_rw || !w_dc_full);

    // A stalled request stays with its source until memory takes it.
    always_comb begin
        w_gnt = 1'b0;
        w_src = SRC_IC;
        if (!reset && r_state == IDLE) begin
            if (r_lock) begin
                w_src = r_lock_src;
                w_gnt = (r_lock_src == SRC_DC) ? dc_mem_req_valid : ic_mem_req_valid;
            end else if (w_ic_elig && w_dc_elig) begin
                w_gnt = 1'b1;
`ifdef MEM_SCHED_DC_PRIORITY_EN
                w_src = SRC_DC;
`else
                w_src = (r_rr_last == SRC_DC) ? SRC_IC : SRC_DC;
`endif
            end else if (w_ic_elig) begin
                w_gnt = 1'b1;
                w_src = SRC_IC;
            end else if (w_dc_elig) begin
                w_gnt = 1'b1;
                w_src = SRC_DC;
            end
        end
    end

    assign w_accept = w_gnt && mem_req_ready;

    assign mem_req_valid    = w_gnt;
    assign mem_req_rw       = w_gnt && (w_src == SRC_DC) && dc_mem_req_rw;
    assign mem_req_addr     = !w_gnt ? '0 :
                              (w_src == SRC_DC) ? dc_mem_req_addr : ic_mem_req_addr;
    assign mem_req_tag      = !w_gnt ? '0 :
                              (w_src == SRC_DC) ? {w_dc_seq, SRC_DC} : {w_ic_seq, SRC_IC};
    assign ic_mem_req_ready = w_gnt && (w_src == SRC_IC) && mem_req_ready;
    assign dc_mem_req_ready = w_gnt && (w_src == SRC_DC) && mem_req_ready;

    assign mem_req_data_valid    = (r_state == WDATA) && dc_mem_req_data_valid;
    assign dc_mem_req_data_ready = (r_state == WDATA) && mem_req_data_ready;
    assign w_wbeat               = mem_req_data_valid && mem_req_data_ready;

    assign w_ic_beat         = !reset && mem_resp_valid && (mem_resp_tag[0] == SRC_IC);
    assign w_dc_beat         = !reset && mem_resp_valid && (mem_resp_tag[0] == SRC_DC);
    assign ic_mem_resp_valid = w_ic_beat;
    assign dc_mem_resp_valid = w_dc_beat;
    assign w_unused_tag      = ^mem_resp_tag[TAG_W-1:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_lock     <= 1'b0;
            r_lock_src <= SRC_IC;
            r_wbeat    <= '0;
`ifndef MEM_SCHED_DC_PRIORITY_EN
            r_rr_last  <= SRC_DC;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_lock <= 1'b0;
`ifndef MEM_SCHED_DC_PRIORITY_EN
                        r_rr_last <= w_src;
`endif
                        if (w_src == SRC_DC && dc_mem_req_rw) begin
                            r_state <= WDATA;
                            r_wbeat <= '0;
                        end
                    end else if (w_gnt) begin
                        r_lock     <= 1'b1;
                        r_lock_src <= w_src;
                    end
                end
                WDATA: begin
                    if (w_wbeat) begin
                        if (r_wbeat == WBW'(DATA_BEATS - 1)) begin
                            r_state <= IDLE;
                            r_wbeat <= '0;
                        end else begin
                            r_wbeat <= r_wbeat + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    mem_out_tracker #(
        .TAG_W      (TAG_W),
        .DATA_BEATS (DATA_BEATS),
        .MAX_OUT    (MAX_OUT)
    ) u_ic_trk (
        .clk         (clk),
        .reset       (reset),
        .i_accept    (w_accept && (w_src == SRC_IC)),
        .i_resp_beat (w_ic_beat),
        .o_seq       (w_ic_seq),
        .o_full      (w_ic_full)
    );

    mem_out_tracker #(
        .TAG_W      (TAG_W),
        .DATA_BEATS (DATA_BEATS),
        .MAX_OUT    (MAX_OUT)
    ) u_dc_trk (
        .clk         (clk),
        .reset       (reset),
        .i_accept    (w_accept && (w_src == SRC_DC) && !dc_mem_req_rw),
        .i_resp_beat (w_dc_beat),
        .o_seq       (w_dc_seq),
        .o_full      (w_dc_full)
    );

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed self-checking bench for mem_req_scheduler; expected values are hand-derived.
// With MEM_SCHED_DC_PRIORITY_EN defined only the fixed-priority sequence runs.
module tb_mem_req_scheduler;

    logic        clk;
    logic        reset;
    logic        ic_mem_req_valid;
    logic        ic_mem_req_ready;
    logic [27:0] ic_mem_req_addr;
    logic        ic_mem_resp_valid;
    logic        dc_mem_req_valid;
    logic        dc_mem_req_ready;
    logic        dc_mem_req_rw;
    logic [27:0] dc_mem_req_addr;
    logic        dc_mem_req_data_valid;
    logic        dc_mem_req_data_ready;
    logic        dc_mem_resp_valid;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [27:0] mem_req_addr;
    logic [4:0]  mem_req_tag;
    logic        mem_req_data_valid;
    logic        mem_req_data_ready;
    logic        mem_resp_valid;
    logic [4:0]  mem_resp_tag;

    int n_chk;
    int n_fail;
    logic [6:0] wdat_pat;

    mem_req_scheduler dut (
        .clk                   (clk),
        .reset                 (reset),
        .ic_mem_req_valid      (ic_mem_req_valid),
        .ic_mem_req_ready      (ic_mem_req_ready),
        .ic_mem_req_addr       (ic_mem_req_addr),
        .ic_mem_resp_valid     (ic_mem_resp_valid),
        .dc_mem_req_valid      (dc_mem_req_valid),
        .dc_mem_req_ready      (dc_mem_req_ready),
        .dc_mem_req_rw         (dc_mem_req_rw),
        .dc_mem_req_addr       (dc_mem_req_addr),
        .dc_mem_req_data_valid (dc_mem_req_data_valid),
        .dc_mem_req_data_ready (dc_mem_req_data_ready),
        .dc_mem_resp_valid     (dc_mem_resp_valid),
        .mem_req_valid         (mem_req_valid),
        .mem_req_ready         (mem_req_ready),
        .mem_req_rw            (mem_req_rw),
        .mem_req_addr          (mem_req_addr),
        .mem_req_tag           (mem_req_tag),
        .mem_req_data_valid    (mem_req_data_valid),
        .mem_req_data_ready    (mem_req_data_ready),
        .mem_resp_valid        (mem_resp_valid),
        .mem_resp_tag          (mem_resp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        ic_mem_req_valid = 1'b0;
        ic_mem_req_addr = '0;
        dc_mem_req_valid = 1'b0;
        dc_mem_req_rw = 1'b0;
        dc_mem_req_addr = '0;
        dc_mem_req_data_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_tag = '0;
        wdat_pat = 7'b1011010;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 0);
        chk("rst_req_addr", 32'(mem_req_addr), 0);
        chk("rst_req_tag", 32'(mem_req_tag), 0);
        chk("rst_ic_ready", 32'(ic_mem_req_ready), 0);
        chk("rst_dc_ready", 32'(dc_mem_req_ready), 0);
        chk("rst_data_valid", 32'(mem_req_data_valid), 0);
        chk("rst_data_ready", 32'(dc_mem_req_data_ready), 0);
        chk("rst_ic_resp", 32'(ic_mem_resp_valid), 0);
        chk("rst_dc_resp", 32'(dc_mem_resp_valid), 0);
        reset = 1'b0;
        step();

`ifdef MEM_SCHED_DC_PRIORITY_EN
        ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000A10;
        dc_mem_req_valid = 1'b1; dc_mem_req_rw = 1'b0; dc_mem_req_addr = 28'h0000D10;
        mem_req_ready = 1'b1;
        #1;
        chk("prio1_addr", 32'(mem_req_addr), 32'h0000D10);
        chk("prio1_tag", 32'(mem_req_tag), 32'h01);
        chk("prio1_dc_ready", 32'(dc_mem_req_ready), 1);
        step();
        chk("prio2_addr", 32'(mem_req_addr), 32'h0000D10);
        chk("prio2_tag", 32'(mem_req_tag), 32'h03);
        chk("prio2_ic_ready", 32'(ic_mem_req_ready), 0);
        step();
        chk("prio3_addr", 32'(mem_req_addr), 32'h0000A10);
        chk("prio3_tag", 32'(mem_req_tag), 32'h00);
        chk("prio3_ic_ready", 32'(ic_mem_req_ready), 1);
        chk("prio3_dc_ready", 32'(dc_mem_req_ready), 0);
        step();
        ic_mem_req_valid = 1'b0; dc_mem_req_valid = 1'b0; mem_req_ready = 1'b0;
`else
        // Round-robin: icache wins the first tie, then the dcache.
        ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000A10;
        dc_mem_req_valid = 1'b1; dc_mem_req_rw = 1'b0; dc_mem_req_addr = 28'h0000D10;
        mem_req_ready = 1'b1;
        #1;
        chk("rr1_valid", 32'(mem_req_valid), 1);
        chk("rr1_addr", 32'(mem_req_addr), 32'h0000A10);
        chk("rr1_tag", 32'(mem_req_tag), 32'h00);
        chk("rr1_ic_ready", 32'(ic_mem_req_ready), 1);
        chk("rr1_dc_ready", 32'(dc_mem_req_ready), 0);
        step();
        chk("rr2_addr", 32'(mem_req_addr), 32'h0000D10);
        chk("rr2_tag", 32'(mem_req_tag), 32'h01);
        chk("rr2_rw", 32'(mem_req_rw), 0);
        chk("rr2_dc_ready", 32'(dc_mem_req_ready), 1);
        chk("rr2_ic_ready", 32'(ic_mem_req_ready), 0);
        step();
        ic_mem_req_valid = 1'b0; dc_mem_req_valid = 1'b0; mem_req_ready = 1'b0;

        // Stalled icache request; dcache joins on the second cycle.
        ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000A20;
        #1;
        chk("stall1_addr", 32'(mem_req_addr), 32'h0000A20);
        chk("stall1_tag", 32'(mem_req_tag), 32'h02);
        chk("stall1_ic_ready", 32'(ic_mem_req_ready), 0);
        step();
        dc_mem_req_valid = 1'b1; dc_mem_req_addr = 28'h0000D20;
        #1;
        chk("stall2_addr", 32'(mem_req_addr), 32'h0000A20);
        chk("stall2_dc_ready", 32'(dc_mem_req_ready), 0);
        step();
        chk("stall3_addr", 32'(mem_req_addr), 32'h0000A20);
        chk("stall3_dc_ready", 32'(dc_mem_req_ready), 0);
        step();
        mem_req_ready = 1'b1;
        #1;
        chk("stall4_addr", 32'(mem_req_addr), 32'h0000A20);
        chk("stall4_ic_ready", 32'(ic_mem_req_ready), 1);
        chk("stall4_dc_ready", 32'(dc_mem_req_ready), 0);
        step();
        ic_mem_req_valid = 1'b0; dc_mem_req_valid = 1'b0; mem_req_ready = 1'b0;

        // Icache holds two reads: a third waits until the tag 0x00 response completes.
        ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000A30;
        #1;
        chk("full_no_grant", 32'(mem_req_valid), 0);
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_tag = 5'h00;
            #1;
            chk("full_ic_resp", 32'(ic_mem_resp_valid), 1);
            chk("full_dc_resp", 32'(dc_mem_resp_valid), 0);
            chk("full_hold", 32'(mem_req_valid), 0);
            step();
        end
        mem_resp_valid = 1'b0;
        #1;
        chk("freed_valid", 32'(mem_req_valid), 1);
        chk("freed_addr", 32'(mem_req_addr), 32'h0000A30);
        chk("freed_tag", 32'(mem_req_tag), 32'h04);
        step();

        // Acceptance coincides with the final beat of tag 0x02.
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_tag = 5'h02;
            mem_req_ready = (i == 3);
            #1;
            chk("same_ic_resp", 32'(ic_mem_resp_valid), 1);
            chk("same_dc_resp", 32'(dc_mem_resp_valid), 0);
            chk("same_tag", 32'(mem_req_tag), 32'h04);
            chk("same_ic_ready", 32'(ic_mem_req_ready), (i == 3) ? 1 : 0);
            step();
        end
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1; ic_mem_req_addr = 28'h0000A40;
        #1;
        chk("same_next_valid", 32'(mem_req_valid), 1);
        chk("same_next_tag", 32'(mem_req_tag), 32'h06);
        step();
        ic_mem_req_addr = 28'h0000A50;
        #1;
        chk("same_then_full", 32'(mem_req_valid), 0);
        ic_mem_req_valid = 1'b0; mem_req_ready = 1'b0;

        // Dcache response, then unexpected dcache beats with nothing outstanding.
        for (int i = 0; i < 8; i++) begin
            mem_resp_valid = 1'b1; mem_resp_tag = (i < 4) ? 5'h01 : 5'h03;
            #1;
            chk("dc_resp", 32'(dc_mem_resp_valid), 1);
            chk("dc_resp_ic", 32'(ic_mem_resp_valid), 0);
            step();
        end
        mem_resp_valid = 1'b0;

        // Dcache write burst with a pending icache read and icache beats during WDATA.
        dc_mem_req_valid = 1'b1; dc_mem_req_rw = 1'b1; dc_mem_req_addr = 28'h0000DF0;
        dc_mem_req_data_valid = 1'b1; mem_req_data_ready = 1'b1; mem_req_ready = 1'b1;
        #1;
        chk("wr_valid", 32'(mem_req_valid), 1);
        chk("wr_rw", 32'(mem_req_rw), 1);
        chk("wr_addr", 32'(mem_req_addr), 32'h0000DF0);
        chk("wr_tag", 32'(mem_req_tag), 32'h03);
        chk("wr_dc_ready", 32'(dc_mem_req_ready), 1);
        chk("wr_idle_data_valid", 32'(mem_req_data_valid), 0);
        chk("wr_idle_data_ready", 32'(dc_mem_req_data_ready), 0);
        step();
        dc_mem_req_valid = 1'b0; dc_mem_req_rw = 1'b0;
        ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000A60;
        for (int i = 0; i < 7; i++) begin
            mem_req_data_ready = wdat_pat[i];
            mem_resp_valid = (i < 4); mem_resp_tag = 5'h04;
            #1;
            chk("wd_data_valid", 32'(mem_req_data_valid), 1);
            chk("wd_data_ready", 32'(dc_mem_req_data_ready), 32'(wdat_pat[i]));
            chk("wd_no_grant", 32'(mem_req_valid), 0);
            chk("wd_ic_ready", 32'(ic_mem_req_ready), 0);
            chk("wd_ic_resp", 32'(ic_mem_resp_valid), (i < 4) ? 1 : 0);
            step();
        end
        mem_resp_valid = 1'b0; mem_req_data_ready = 1'b1;
        #1;
        chk("wd_end_data_valid", 32'(mem_req_data_valid), 0);
        chk("wd_end_data_ready", 32'(dc_mem_req_data_ready), 0);
        chk("wd_end_valid", 32'(mem_req_valid), 1);
        chk("wd_end_addr", 32'(mem_req_addr), 32'h0000A60);
        chk("wd_end_tag", 32'(mem_req_tag), 32'h08);
        chk("wd_end_ic_ready", 32'(ic_mem_req_ready), 1);
        step();
        dc_mem_req_data_valid = 1'b0; mem_req_data_ready = 1'b0;
        ic_mem_req_valid = 1'b0; mem_req_ready = 1'b0;

        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_tag = 5'h06;
            #1;
            chk("drain_ic_resp", 32'(ic_mem_resp_valid), 1);
            step();
        end
        mem_resp_valid = 1'b0;

        // Lock: icache granted alone keeps the channel although dcache would now win.
        ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000A70;
        #1;
        chk("lock1_addr", 32'(mem_req_addr), 32'h0000A70);
        chk("lock1_tag", 32'(mem_req_tag), 32'h0A);
        step();
        dc_mem_req_valid = 1'b1; dc_mem_req_rw = 1'b0; dc_mem_req_addr = 28'h0000D30;
        #1;
        chk("lock2_addr", 32'(mem_req_addr), 32'h0000A70);
        chk("lock2_dc_ready", 32'(dc_mem_req_ready), 0);
        step();
        mem_req_ready = 1'b1;
        #1;
        chk("lock3_addr", 32'(mem_req_addr), 32'h0000A70);
        chk("lock3_ic_ready", 32'(ic_mem_req_ready), 1);
        step();
        ic_mem_req_valid = 1'b0;
        #1;
        chk("lock4_valid", 32'(mem_req_valid), 1);
        chk("lock4_addr", 32'(mem_req_addr), 32'h0000D30);
        chk("lock4_tag", 32'(mem_req_tag), 32'h03);
        chk("lock4_dc_ready", 32'(dc_mem_req_ready), 1);
        step();
        dc_mem_req_valid = 1'b0; mem_req_ready = 1'b0;
`endif
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
